// File: rtl/gf180mcu_osu_sc_ro_meter_pkg.sv
// Shared FSM encoding and default sizing for the gp12t3v3 ring-oscillator meter.
package gf180mcu_osu_sc_ro_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } ro_state_e;

  localparam int RO_METER_CW     = 16;
  localparam int RO_METER_WINDOW = 1024;
  localparam int RO_METER_SETTLE = 16;

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__ro_sync.sv
// Brings the free-running ring output into the CLK domain and flags its rising edges.
module gf180mcu_osu_sc_gp12t3v3__ro_sync (
  input  logic CLK,
  input  logic RN,
  input  logic ro,
  output logic ro_edge
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= ro;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign ro_edge = s2_r & ~s3_r;

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__ro_meter.sv
// Ring-oscillator frequency meter: enables the ring, settles, counts edges over a CLK window.
// Define GF180MCU_OSU_SC_RO_METER_CONT_EN for back-to-back windows while START is held.
module gf180mcu_osu_sc_gp12t3v3__ro_meter
  import gf180mcu_osu_sc_ro_meter_pkg::*;
#(
  parameter int CW     = RO_METER_CW,
  parameter int WINDOW = RO_METER_WINDOW,
  parameter int SETTLE = RO_METER_SETTLE
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          START,
  input  logic          ABORT,
  input  logic          RO,
  output logic          RO_EN,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] COUNT,
  output logic          OVF
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [WW-1:0] WINDOW_LAST = WW'(WINDOW - 1);

  ro_state_e     state_r;
  ro_state_e     state_nxt_s;
  logic [SW-1:0] settle_cnt_r;
  logic [WW-1:0] win_cnt_r;
  logic [CW-1:0] edge_cnt_r;
  logic [CW-1:0] edge_cnt_nxt_s;
  logic          ovf_r;
  logic          ovf_nxt_s;
  logic          ro_edge_s;

  gf180mcu_osu_sc_gp12t3v3__ro_sync u_sync (
    .CLK     (CLK),
    .RN      (RN),
    .ro      (RO),
    .ro_edge (ro_edge_s)
  );

  // next-state logic; ABORT always wins over START
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START && !ABORT) state_nxt_s = ST_SETTLE;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (ABORT)                             state_nxt_s = ST_IDLE;
        else if (settle_cnt_r == SETTLE_LAST)  state_nxt_s = ST_MEASURE;
        else                                   state_nxt_s = ST_SETTLE;
      end
      ST_MEASURE: begin
        if (ABORT)                          state_nxt_s = ST_IDLE;
        else if (win_cnt_r == WINDOW_LAST)  state_nxt_s = ST_DONE;
        else                                state_nxt_s = ST_MEASURE;
      end
      ST_DONE: begin
`ifdef GF180MCU_OSU_SC_RO_METER_CONT_EN
        if (START && !ABORT) state_nxt_s = ST_SETTLE;
        else                 state_nxt_s = ST_IDLE;
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // settle and window counters run only while their state is active
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      settle_cnt_r <= '0;
      win_cnt_r    <= '0;
    end else begin
      if (state_r == ST_SETTLE) settle_cnt_r <= settle_cnt_r + SW'(1);
      else                      settle_cnt_r <= '0;
      if (state_r == ST_MEASURE) win_cnt_r <= win_cnt_r + WW'(1);
      else                       win_cnt_r <= '0;
    end
  end

  // saturating edge count; cleared as MEASURE is entered
  always_comb begin
    edge_cnt_nxt_s = edge_cnt_r;
    ovf_nxt_s      = ovf_r;
    if (state_r == ST_SETTLE && state_nxt_s == ST_MEASURE) begin
      edge_cnt_nxt_s = '0;
      ovf_nxt_s      = 1'b0;
    end else if (state_r == ST_MEASURE && ro_edge_s) begin
      if (edge_cnt_r == {CW{1'b1}}) ovf_nxt_s      = 1'b1;
      else                          edge_cnt_nxt_s = edge_cnt_r + CW'(1);
    end else begin
      edge_cnt_nxt_s = edge_cnt_r;
      ovf_nxt_s      = ovf_r;
    end
  end

  // edge counter register
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      edge_cnt_r <= '0;
      ovf_r      <= 1'b0;
    end else begin
      edge_cnt_r <= edge_cnt_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

  // outputs registered from the next state so they align with the state itself
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      RO_EN <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      COUNT <= '0;
      OVF   <= 1'b0;
    end else begin
      RO_EN <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_MEASURE);
      BUSY  <= (state_nxt_s != ST_IDLE);
      DONE  <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_DONE) begin
        COUNT <= edge_cnt_nxt_s;
        OVF   <= ovf_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__ro_meter.sv
// Randomised self-checking bench for the ring-oscillator meter (single-shot build).
module tb_gf180mcu_osu_sc_gp12t3v3__ro_meter;

  localparam int P_CW     = 4;
  localparam int P_WINDOW = 64;
  localparam int P_SETTLE = 4;
  localparam int MAXC     = 8192;

  logic            CLK = 1'b0;
  logic            RN;
  logic            START;
  logic            ABORT;
  logic            RO;
  logic            RO_EN;
  logic            BUSY;
  logic            DONE;
  logic [P_CW-1:0] COUNT;
  logic            OVF;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit ro_hist [0:MAXC-1];
  int ro_mode = 0;
  int ro_half = 2;
  int ro_ph   = 0;
  int prev_count = 0;
  bit prev_ovf   = 1'b0;

  gf180mcu_osu_sc_gp12t3v3__ro_meter #(
    .CW     (P_CW),
    .WINDOW (P_WINDOW),
    .SETTLE (P_SETTLE)
  ) dut (
    .CLK   (CLK),
    .RN    (RN),
    .START (START),
    .ABORT (ABORT),
    .RO    (RO),
    .RO_EN (RO_EN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .COUNT (COUNT),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock; RO for the new cycle is driven and logged just after the edge
  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
    if (ro_mode == 0) begin
      RO = 1'b0;
    end else begin
      ro_ph++;
      if (ro_ph >= ro_half) begin
        ro_ph = 0;
        RO = ~RO;
        if (ro_mode == 2) ro_half = $urandom_range(2, 6);
      end
    end
    if (cyc < MAXC) ro_hist[cyc] = RO;
  endtask

  // rising RO transitions that land inside the measurement window (3-cycle shift)
  function automatic int model_edges(input int n0);
    int c = 0;
    for (int k = n0 + P_SETTLE - 2; k <= n0 + P_SETTLE + P_WINDOW - 3; k++)
      if (!ro_hist[k-1] && ro_hist[k]) c++;
    return c;
  endfunction

  // one measurement; abort_at>0 raises ABORT for the edge abort_at cycles after acceptance
  task automatic run(input int abort_at, input string tag);
    int n0;
    int ea;
    int last_done;
    int exp_c;
    bit exp_o;
    bit aborted;
    aborted   = (abort_at > 0);
    n0        = cyc + 1;
    ea        = n0 + abort_at;
    last_done = n0 + P_SETTLE + P_WINDOW;
    for (int e = n0; e <= last_done + 2; e++) begin
      if (e == n0) START = 1'b1;
      else if (e <= (aborted ? ea : last_done + 1)) START = ($urandom_range(0, 5) == 0);
      else START = 1'b0;
      ABORT = aborted && (e == ea);
      tick();
      if (!aborted && cyc == last_done) begin
        exp_c = model_edges(n0);
        exp_o = (exp_c > (2**P_CW - 1));
        if (exp_o) exp_c = 2**P_CW - 1;
        prev_count = exp_c;
        prev_ovf   = exp_o;
      end
      chk({tag, ".ro_en"}, RO_EN, (cyc >= n0) && (cyc < (aborted ? ea : last_done)));
      chk({tag, ".busy"},  BUSY,  (cyc >= n0) && (cyc < (aborted ? ea : last_done + 1)));
      chk({tag, ".done"},  DONE,  !aborted && (cyc == last_done));
      chk({tag, ".count"}, COUNT, prev_count);
      chk({tag, ".ovf"},   OVF,   prev_ovf);
    end
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  initial begin
    RN = 1'b0; START = 1'b0; ABORT = 1'b0; RO = 1'b0;
    ro_hist[0] = 1'b0;
    tick(); tick();
    chk("rst.ro_en", RO_EN, 1'b0);
    chk("rst.busy",  BUSY,  1'b0);
    chk("rst.done",  DONE,  1'b0);
    chk("rst.count", COUNT, 0);
    chk("rst.ovf",   OVF,   1'b0);
    RN = 1'b1;
    repeat (4) tick();
    chk("idle.busy", BUSY, 1'b0);

    ro_mode = 1; ro_half = 4; ro_ph = 0;
    run(0, "p8");
    chk("p8.const", COUNT, 8);

    ro_mode = 0;
    run(0, "zero");
    chk("zero.const", COUNT, 0);

    ro_mode = 1; ro_half = 2; ro_ph = 0;
    run(0, "p4sat");
    chk("p4sat.count", COUNT, 15);
    chk("p4sat.ovf",   OVF,   1'b1);

    ro_mode = 0;
    run(0, "zero2");
    chk("zero2.ovf", OVF, 1'b0);

    ro_mode = 1; ro_half = 4; ro_ph = 0;
    run(0, "p8b");
    run(P_SETTLE + 10, "abort");
    chk("abort.hold", COUNT, 8);

    START = 1'b1; ABORT = 1'b1;
    tick();
    chk("sa.busy",  BUSY,  1'b0);
    chk("sa.ro_en", RO_EN, 1'b0);
    START = 1'b0; ABORT = 1'b0;
    tick();
    chk("sa.busy2", BUSY, 1'b0);

    ro_mode = 2;
    for (int i = 0; i < 10; i++) begin
      run(($urandom_range(0, 2) == 0) ? $urandom_range(1, P_SETTLE + P_WINDOW) : 0, "rnd");
      repeat ($urandom_range(0, 3)) tick();
    end

    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (P_SETTLE + 5) tick();
    chk("mid.busy",  BUSY,  1'b1);
    chk("mid.ro_en", RO_EN, 1'b1);
    #2;
    RN = 1'b0;
    #1;
    chk("arst.ro_en", RO_EN, 1'b0);
    chk("arst.busy",  BUSY,  1'b0);
    chk("arst.done",  DONE,  1'b0);
    chk("arst.count", COUNT, 0);
    chk("arst.ovf",   OVF,   1'b0);
    RN = 1'b1;
    prev_count = 0;
    prev_ovf   = 1'b0;
    for (int i = 0; i < P_SETTLE + P_WINDOW + 4; i++) begin
      tick();
      chk("arst.nodone", DONE, 1'b0);
    end

    ro_mode = 1; ro_half = 4; ro_ph = 0;
    run(0, "recover");
    chk("recover.const", COUNT, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
